rsa_key_setup: RTL and testbench
================================

# rsa_key_setup

Sequential RSA key-setup stage sitting directly upstream of the RSA encrypt/decrypt core. It takes the primes p, q and public exponent e, and computes modulus n = p·q and private exponent d = e⁻¹ mod φ(n) using an iterative extended Euclidean algorithm. It also flags invalid key material before the exponentiation core consumes n, e and d.

## Interface
- PW, 16, prime width; NW = 2·PW is the derived width of n, φ, e and d.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- p  in  PW  prime p.
- q  in  PW  prime q.
- ext_e  in  NW  public exponent e.
- busy  out  1  high from the cycle after an accepted start until the cycle done is high, inclusive.
- done  out  1  one-cycle pulse; n, e_o, d, invalid are valid from that cycle.
- n  out  NW  modulus p·q.
- e_o  out  NW  latched e, passed downstream.
- d  out  NW  private exponent; 0 when invalid.
- invalid  out  1  key material rejected.

## Operation
- Reset: busy=0, done=0, invalid=0, n=0, e_o=0, d=0. State is IDLE.
- IDLE:
  - start=1 latches p, q, ext_e.
  - Clears n, d and invalid; sets busy; goes to CHECK.
  - start while busy=1 is ignored and not queued.
- CHECK (1 cycle):
  - Computes n = p·q and φ = (p−1)(q−1), both NW bits and exact.
  - The key is invalid if p<2, q<2, p==q, e<2 or e≥φ.
  - Invalid → DONE with invalid=1, d=0. Otherwise initialise r_prev=φ, r=e, t_prev=0, t=1 and go to DIV.
- DIV: pulses the divider start with dividend r_prev and divisor r, then goes to WAIT.
- WAIT: holds until the divider reports done, then goes to UPDATE.
- UPDATE: (r_prev, r) ← (r, rem) and (t_prev, t) ← (t, t_prev − quot·t).
  - t arithmetic is two's complement, NW+2 bits signed; the quot·t product is truncated to that width.
  - rem≠0 → DIV; rem==0 → FINAL.
- FINAL:
  - gcd = r_prev. gcd≠1 → invalid=1, d=0.
  - Otherwise d = t_prev<0 ? t_prev+φ : t_prev.
  - Goes to DONE.
- DONE: done=1 for exactly one cycle, busy drops, returns to IDLE. Outputs hold until the next accepted start.
- rst mid-operation: aborts on that edge with all outputs at reset values; no done pulse.
- Simultaneous rst and start: rst wins and start is lost.

## Timing
- Divider latency is NW cycles from its start pulse to its done, which makes each EEA iteration NW+2 = 34 cycles at PW=16.
- Valid key: done asserts 3 + 34·k cycles after the edge that sampled start, where k is the number of EEA divisions.
- Invalid at CHECK: done asserts 2 cycles after start.
- Throughput is one key per operation; no pipelining.

## Configuration
- RSA_KEYGEN_SELFCHECK_EN defined: FINAL issues one extra division, (e·d) mod φ, costing 34 more cycles.
  - Result ≠1 → invalid=1, d=0.
  - Latency for a valid key becomes 3 + 34·(k+1).
- Undefined: no self-check and the base latency applies. Outputs are otherwise identical.

## Structure
- Shared package rsa_pkg holds:
  - PW/NW defaults;
  - the state enum IDLE, CHECK, DIV, WAIT, UPDATE, FINAL, DONE, plus SELFCHK under the macro;
  - the divider latency constant.
- One sub-module, rsa_seq_div: restoring unsigned NW-bit divider.
  - Ports: clk, rst, start, dividend, divisor.
  - Outputs quot, rem and a one-cycle done exactly NW cycles after start.
  - Divisor 0 never occurs, because r≠0 is guaranteed by the FSM.

## Test plan
- p=2, q=7, e=5 → n=14, d=5, invalid=0; k=2, done at cycle 71 (105 with self-check).
- p=61, q=53, e=17 → n=3233, d=2753, invalid=0; k=4, done at cycle 139.
- p=5, q=11, e=5 (gcd(5,40)=5) → invalid=1, d=0, n=55 after full EEA.
- p=1, q=7, e=5, and separately p=2, q=7, e=7 (e≥φ) → invalid=1, d=0, done 2 cycles after start.
- Second start pulsed while busy is ignored and the result is unchanged. rst asserted in WAIT → next cycle busy=0, outputs 0, no done; a fresh start completes normally.
- Back-to-back keys (start in the cycle after done) → each result is correct; n/d are cleared at acceptance and updated at done.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA key-setup stage: default widths, FSM
// state encoding and the sequential divider latency.
// Optional feature macro: RSA_KEYGEN_SELFCHECK_EN adds the SELFCHK state.
package rsa_pkg;

  localparam int PW_DEF  = 16;
  localparam int NW_DEF  = 2 * PW_DEF;
  // One quotient bit per cycle, so the divider latency equals its width.
  localparam int DIV_LAT = NW_DEF;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DIV,
    WAIT,
    UPDATE,
    FINAL,
    DONE
`ifdef RSA_KEYGEN_SELFCHECK_EN
    , SELFCHK
`endif
  } state_t;

endpackage

// File: rtl/rsa_seq_div.sv
// Restoring unsigned sequential divider. The first quotient bit is
// resolved on the start edge, so done pulses exactly W cycles after start.
// A zero divisor never reaches this block.
module rsa_seq_div
  import rsa_pkg::*;
#(
  parameter int W = DIV_LAT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, quo_q, dsr_q;
  logic [CW-1:0] cnt;
  logic          active;

  logic [W-1:0]  src_rem, src_quo, src_dsr, nxt_rem, nxt_quo;
  logic [W:0]    trial;
  logic          qbit;

  // One restoring step; on the start cycle it works straight from the inputs.
  always_comb begin
    src_rem = start ? '0       : rem_q;
    src_quo = start ? dividend : quo_q;
    src_dsr = start ? divisor  : dsr_q;
    trial   = {src_rem, src_quo[W-1]};
    if (trial >= {1'b0, src_dsr}) begin
      nxt_rem = W'(trial - {1'b0, src_dsr});
      qbit    = 1'b1;
    end else begin
      nxt_rem = trial[W-1:0];
      qbit    = 1'b0;
    end
    nxt_quo = {src_quo[W-2:0], qbit};
  end

  // Step counter and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        active <= 1'b1;
        cnt    <= CW'(1);
      end else if (active) begin
        cnt <= cnt + CW'(1);
        if (cnt == CW'(W - 1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  // Partial remainder / quotient shift register and latched divisor.
  always_ff @(posedge clk) begin
    if (start || active) begin
      rem_q <= nxt_rem;
      quo_q <= nxt_quo;
    end
    if (start) dsr_q <= divisor;
  end

  assign quot = quo_q;
  assign rem  = rem_q;

endmodule

// File: rtl/rsa_key_setup.sv
// RSA key setup: n = p*q and d = e^-1 mod phi(n) via iterative extended
// Euclid on a shared sequential divider; flags unusable key material.
// Optional feature macro: RSA_KEYGEN_SELFCHECK_EN verifies (e*d) mod phi == 1
// before reporting the key.
module rsa_key_setup
  import rsa_pkg::*;
#(
  parameter int PW = PW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [PW-1:0]   p,
  input  logic [PW-1:0]   q,
  input  logic [2*PW-1:0] ext_e,
  output logic            busy,
  output logic            done,
  output logic [2*PW-1:0] n,
  output logic [2*PW-1:0] e_o,
  output logic [2*PW-1:0] d,
  output logic            invalid
);

  localparam int NW = 2 * PW;
  localparam int TW = NW + 2;

  // Bring a Bezout coefficient in (-phi, phi) into [0, phi).
  function automatic logic [NW-1:0] wrap_mod(input logic signed [TW-1:0] tv,
                                              input logic [NW-1:0] m);
    return tv[TW-1] ? NW'(tv + $signed({2'b00, m})) : NW'(tv);
  endfunction

`ifdef RSA_KEYGEN_SELFCHECK_EN
  // One MSB-first step of the modular product: (2*acc + b*e) mod m.
  function automatic logic [NW-1:0] mod_dbl_add(input logic [NW-1:0] acc,
                                                 input logic b,
                                                 input logic [NW-1:0] e,
                                                 input logic [NW-1:0] m);
    logic [NW:0] s;
    s = {acc, 1'b0};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    if (b) begin
      s = s + {1'b0, e};
      if (s >= {1'b0, m}) s = s - {1'b0, m};
    end
    return s[NW-1:0];
  endfunction

  localparam int SCW = $clog2(NW + 2);
  logic [NW-1:0]  sc_acc, sc_bits;
  logic [SCW-1:0] sc_cnt;
`endif

  state_t state;

  logic [PW-1:0]          p_r, q_r;
  logic [NW-1:0]          n_c, phi, r_prev, r_cur, d_c;
  logic signed [TW-1:0]   t_prev, t_cur, prod;
  logic                   inv_c;

  logic [PW-1:0]          pm1, qm1;
  logic [NW-1:0]          n_calc, phi_calc;
  logic                   bad;

  logic                   div_start, div_done;
  logic [NW-1:0]          div_quot, div_rem;

  // Key screening arithmetic for the CHECK cycle.
  always_comb begin
    pm1      = p_r - PW'(1);
    qm1      = q_r - PW'(1);
    n_calc   = NW'(p_r) * NW'(q_r);
    phi_calc = NW'(pm1) * NW'(qm1);
    bad      = (p_r < PW'(2)) || (q_r < PW'(2)) || (p_r == q_r) ||
               (e_o < NW'(2)) || (e_o >= phi_calc);
  end

  // quot*t wraps to the signed coefficient width.
  assign prod      = $signed({2'b00, div_quot}) * t_cur;
  assign div_start = (state == DIV);

  rsa_seq_div #(
    .W (NW)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (r_prev),
    .divisor  (r_cur),
    .quot     (div_quot),
    .rem      (div_rem),
    .done     (div_done)
  );

  // Key-setup FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      invalid <= 1'b0;
      n       <= '0;
      e_o     <= '0;
      d       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start && !busy) begin
            p_r     <= p;
            q_r     <= q;
            e_o     <= ext_e;
            n       <= '0;
            d       <= '0;
            invalid <= 1'b0;
            busy    <= 1'b1;
            state   <= CHECK;
          end
        end
        CHECK: begin
          n_c    <= n_calc;
          phi    <= phi_calc;
          inv_c  <= bad;
          r_prev <= phi_calc;
          r_cur  <= e_o;
          t_prev <= '0;
          t_cur  <= TW'(1);
          state  <= bad ? DONE : DIV;
        end
        DIV: state <= WAIT;
        WAIT: if (div_done) state <= UPDATE;
        UPDATE: begin
          r_prev <= r_cur;
          r_cur  <= div_rem;
          t_prev <= t_cur;
          t_cur  <= t_prev - prod;
          state  <= (div_rem == '0) ? FINAL : DIV;
        end
        FINAL: begin
          d_c <= wrap_mod(t_prev, phi);
          if (r_prev != NW'(1)) begin
            inv_c <= 1'b1;
            state <= DONE;
          end else begin
`ifdef RSA_KEYGEN_SELFCHECK_EN
            sc_acc  <= '0;
            sc_bits <= wrap_mod(t_prev, phi);
            sc_cnt  <= '0;
            state   <= SELFCHK;
`else
            state   <= DONE;
`endif
          end
        end
`ifdef RSA_KEYGEN_SELFCHECK_EN
        SELFCHK: begin
          sc_cnt <= sc_cnt + SCW'(1);
          if (sc_cnt < SCW'(NW)) begin
            sc_acc  <= mod_dbl_add(sc_acc, sc_bits[NW-1], e_o, phi);
            sc_bits <= sc_bits << 1;
          end else if (sc_cnt == SCW'(NW + 1)) begin
            if (sc_acc != NW'(1)) inv_c <= 1'b1;
            state <= DONE;
          end
        end
`endif
        DONE: begin
          done    <= 1'b1;
          n       <= n_c;
          invalid <= inv_c;
          d       <= inv_c ? '0 : d_c;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_key_setup.sv
// Directed + randomized bench for rsa_key_setup against an arithmetic
// reference model of RSA key setup (modulus, modular inverse, latency).
module tb_rsa_key_setup;

`ifdef RSA_KEYGEN_SELFCHECK_EN
  localparam int SC = 1;
`else
  localparam int SC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] p = '0, q = '0;
  logic [31:0] ext_e = '0;
  logic        busy, done, invalid;
  logic [31:0] n, e_o, d;

  int checks = 0;
  int errors = 0;

  rsa_key_setup dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .p       (p),
    .q       (q),
    .ext_e   (ext_e),
    .busy    (busy),
    .done    (done),
    .n       (n),
    .e_o     (e_o),
    .d       (d),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: RSA rules with plain integer arithmetic.
  function automatic void model(input longint mp, input longint mq, input longint me,
                                output longint mn, output longint md,
                                output bit minv, output int mlat);
    longint phi, a, b, x0, x1, qq, rr, tmp;
    int k;
    mn = mp * mq;
    md = 0;
    minv = 1'b0;
    phi = (mp - 1) * (mq - 1);
    if (mp < 2 || mq < 2 || mp == mq || me < 2 || me >= phi) begin
      minv = 1'b1;
      mlat = 2;
      return;
    end
    a = phi; b = me; x0 = 0; x1 = 1; k = 0;
    while (b != 0) begin
      qq = a / b;
      rr = a % b;
      a = b;
      b = rr;
      tmp = x0 - qq * x1;
      x0 = x1;
      x1 = tmp;
      k++;
    end
    if (a != 1) begin
      minv = 1'b1;
      mlat = 3 + 34 * k;
    end else begin
      md = ((x0 % phi) + phi) % phi;
      mlat = 3 + 34 * (k + SC);
    end
  endfunction

  function automatic bit is_prime(input int x);
    if (x < 2) return 1'b0;
    for (int i = 2; i * i <= x; i++)
      if (x % i == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int next_prime(input int x);
    int y;
    y = x;
    while (!is_prime(y)) y++;
    return y;
  endfunction

  // Issue one key and check every output against the model.
  task automatic run_key(input longint kp, input longint kq, input longint ke,
                         input bit inject, input string tag,
                         output int lat, output logic [31:0] dout);
    longint en, ed, phi;
    bit einv;
    int elat, cyc;
    bit seen;
    model(kp, kq, ke, en, ed, einv, elat);
    phi = (kp - 1) * (kq - 1);
    @(negedge clk);
    p = kp[15:0]; q = kq[15:0]; ext_e = ke[31:0]; start = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".acc_busy"}, busy, 1);
    chk({tag, ".acc_n_clr"}, n, 0);
    chk({tag, ".acc_d_clr"}, d, 0);
    @(negedge clk);
    start = 1'b0;
    cyc = 0; seen = 1'b0;
    while (cyc < 3000 && !seen) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) seen = 1'b1;
      else if (inject && cyc == 10) begin
        start = 1'b1; p = 16'd3; q = 16'd5; ext_e = 32'd3;
      end else if (inject && cyc == 12) start = 1'b0;
    end
    lat = cyc;
    dout = d;
    chk({tag, ".done_seen"}, seen, 1);
    chk({tag, ".latency"}, cyc, elat);
    chk({tag, ".n"}, n, en);
    chk({tag, ".d"}, d, ed);
    chk({tag, ".invalid"}, invalid, einv);
    chk({tag, ".e_o"}, e_o, ke);
    chk({tag, ".busy_at_done"}, busy, 1);
    if (!einv) chk({tag, ".ed_mod_phi"}, (longint'(ke) * longint'(d)) % phi, 1);
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, done, 0);
    chk({tag, ".busy_after"}, busy, 0);
  endtask

  initial begin
    int lat, cnt;
    logic [31:0] dv;
    int rp, rq, re;

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.invalid", invalid, 0);
    chk("rst.n", n, 0);
    chk("rst.e_o", e_o, 0);
    chk("rst.d", d, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed test-plan keys.
    run_key(2, 7, 5, 1'b0, "k_2_7_5", lat, dv);
    chk("k_2_7_5.lat_plan", lat, SC ? 105 : 71);
    chk("k_2_7_5.d_plan", dv, 5);
    run_key(61, 53, 17, 1'b1, "k_61_53_17", lat, dv);
    chk("k_61_53_17.lat_plan", lat, SC ? 173 : 139);
    chk("k_61_53_17.d_plan", dv, 2753);
    // Back-to-back: next start lands in the cycle after done.
    run_key(5, 11, 5, 1'b0, "gcd_bad", lat, dv);
    run_key(1, 7, 5, 1'b0, "p_lt2", lat, dv);
    chk("p_lt2.lat_plan", lat, 2);
    run_key(2, 7, 7, 1'b0, "e_ge_phi", lat, dv);
    chk("e_ge_phi.lat_plan", lat, 2);
    run_key(7, 7, 5, 1'b0, "p_eq_q", lat, dv);
    run_key(11, 13, 1, 1'b0, "e_lt2", lat, dv);

    // Reset while the divider is running.
    @(negedge clk);
    p = 16'd61; q = 16'd53; ext_e = 32'd17; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.n", n, 0);
    chk("midrst.e_o", e_o, 0);
    chk("midrst.d", d, 0);
    chk("midrst.invalid", invalid, 0);
    rst = 1'b0;
    cnt = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (done || busy) cnt++;
    end
    chk("midrst.quiet", cnt, 0);
    run_key(61, 53, 17, 1'b0, "after_rst", lat, dv);

    // Reset and start together: start is lost.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; p = 16'd61; q = 16'd53; ext_e = 32'd17;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) cnt++;
    end
    chk("rst_start.lost", cnt, 0);

    // Randomized keys from random primes and random odd exponents.
    for (int i = 0; i < 8; i++) begin
      rp = next_prime(int'($urandom_range(2, 65500)));
      rq = next_prime(int'($urandom_range(2, 65500)));
      re = int'($urandom_range(3, 70000)) | 1;
      run_key(longint'(rp), longint'(rq), longint'(re), 1'b0,
              $sformatf("rnd%0d", i), lat, dv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
